// File: rtl/hart_mem_viewer.sv
// Browsable memory viewer: debounced inc/dec keys step a read address, word and address shown on 7-seg.
// Optional auto-scan compiled in with `define HART_MEM_VIEWER_AUTOSCAN_EN.

module hart_mem_viewer_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_next_s;
    logic             press_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Count consecutive samples disagreeing with the accepted level; a flip to low is a press.
    always_comb begin
        level_next_s = level_r;
        press_next_s = 1'b0;
        cnt_next_s   = cnt_r;
        if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_next_s = sync2_r;
                press_next_s = ~sync2_r;
                cnt_next_s   = {CNT_W{1'b0}};
            end else begin
                cnt_next_s   = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = {CNT_W{1'b0}};
        end
    end

    // Synchroniser, stable-level counter and press pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            level_r <= level_next_s;
            press_r <= press_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign press = press_r;
endmodule

module hart_mem_viewer #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int HEX_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_inc_n,
    input  logic                    key_dec_n,
    input  logic                    auto_mode,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic [7*HEX_DIGITS-1:0] hex,
    output logic [7:0]              leds
);
    localparam int DATA_DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int ADDR_DIGITS = (ADDR_WIDTH + 3) / 4;
    localparam int LED_W       = (DATA_WIDTH < 8) ? DATA_WIDTH : 8;

    if (DATA_DIGITS + ADDR_DIGITS > HEX_DIGITS) begin : g_cfg_err
        $error("hart_mem_viewer: HEX_DIGITS too small for data and address");
    end

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic                    inc_press_s;
    logic                    dec_press_s;
    logic                    auto_active_s;
    logic                    scan_step_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_next_s;
    logic [ADDR_WIDTH-1:0]   addr_d_r;
    logic                    disp_vld_r;
    logic [7*HEX_DIGITS-1:0] hex_r;
    logic [7*HEX_DIGITS-1:0] hex_next_s;
    logic [7:0]              leds_r;
    logic [7:0]              leds_next_s;
    logic [4*DATA_DIGITS-1:0] data_pad_s;
    logic [4*ADDR_DIGITS-1:0] addr_pad_s;

    hart_mem_viewer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk   (clk),
        .reset (reset),
        .key_n (key_inc_n),
        .press (inc_press_s)
    );

    hart_mem_viewer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk   (clk),
        .reset (reset),
        .key_n (key_dec_n),
        .press (dec_press_s)
    );

`ifdef HART_MEM_VIEWER_AUTOSCAN_EN
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    logic              auto_sync1_r;
    logic              auto_sync2_r;
    logic [SCAN_W-1:0] scan_cnt_r;

    // Auto-mode synchroniser and scan period counter, parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_sync1_r <= 1'b0;
            auto_sync2_r <= 1'b0;
            scan_cnt_r   <= {SCAN_W{1'b0}};
        end else begin
            auto_sync1_r <= auto_mode;
            auto_sync2_r <= auto_sync1_r;
            if (!auto_sync2_r || scan_cnt_r == SCAN_LAST) begin
                scan_cnt_r <= {SCAN_W{1'b0}};
            end else begin
                scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            end
        end
    end

    assign auto_active_s = auto_sync2_r;
    assign scan_step_s   = auto_sync2_r && (scan_cnt_r == SCAN_LAST);
`else
    logic auto_mode_unused_s;

    assign auto_mode_unused_s = auto_mode;
    assign auto_active_s      = 1'b0;
    assign scan_step_s        = 1'b0;
`endif

    // Next address: auto-scan owns the register while active, otherwise exactly one key press moves it.
    always_comb begin
        addr_next_s = addr_r;
        if (auto_active_s) begin
            if (scan_step_s) begin
                addr_next_s = addr_r + ADDR_WIDTH'(1);
            end else begin
                addr_next_s = addr_r;
            end
        end else if (inc_press_s && !dec_press_s) begin
            addr_next_s = addr_r + ADDR_WIDTH'(1);
        end else if (dec_press_s && !inc_press_s) begin
            addr_next_s = addr_r - ADDR_WIDTH'(1);
        end else begin
            addr_next_s = addr_r;
        end
    end

    // Address register feeding the memory read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            addr_r <= addr_next_s;
        end
    end

    assign rd_addr = addr_r;

    // Zero-pad data and the delayed address to whole nibbles.
    always_comb begin
        data_pad_s                 = {(4*DATA_DIGITS){1'b0}};
        data_pad_s[DATA_WIDTH-1:0] = rd_data;
        addr_pad_s                 = {(4*ADDR_DIGITS){1'b0}};
        addr_pad_s[ADDR_WIDTH-1:0] = addr_d_r;
        leds_next_s                = 8'h00;
        leds_next_s[LED_W-1:0]     = rd_data[LED_W-1:0];
    end

    for (genvar k = 0; k < HEX_DIGITS; k++) begin : g_digit
        if (k < DATA_DIGITS) begin : g_data
            assign hex_next_s[7*k +: 7] = seg_glyph(data_pad_s[4*k +: 4]);
        end else if (k < DATA_DIGITS + ADDR_DIGITS) begin : g_addr
            assign hex_next_s[7*k +: 7] = seg_glyph(addr_pad_s[4*(k-DATA_DIGITS) +: 4]);
        end else begin : g_blank
            assign hex_next_s[7*k +: 7] = 7'h7F;
        end
    end

    // addr_d_r pairs the returning word with the address that fetched it; the first post-reset word is skipped.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_d_r   <= {ADDR_WIDTH{1'b0}};
            disp_vld_r <= 1'b0;
            hex_r      <= {(7*HEX_DIGITS){1'b1}};
            leds_r     <= 8'h00;
        end else begin
            addr_d_r   <= addr_r;
            disp_vld_r <= 1'b1;
            if (disp_vld_r) begin
                hex_r  <= hex_next_s;
                leds_r <= leds_next_s;
            end else begin
                hex_r  <= hex_r;
                leds_r <= leds_r;
            end
        end
    end

    assign hex  = hex_r;
    assign leds = leds_r;
endmodule

// File: doc/hart_mem_viewer.md
# hart_mem_viewer

Parametrised memory-inspection front end for the hart demo top level. It replaces the fixed "one RAM byte on LEDR" readout with a browsable view. The user steps a read address with two debounced push-buttons, or lets it auto-scan. The addressed word and its address are shown on the seven-segment displays, and the low data byte is mirrored on the LEDs. The block sits between the board I/O and a one-cycle-latency read port into the hart's state memory.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of the read address; the address wraps at 2^ADDR_WIDTH.
- DATA_WIDTH, 8: width of the memory word displayed.
- HEX_DIGITS, 6: number of seven-segment digits driven.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a button level.
- SCAN_CYCLES, 25000000: clock cycles per auto-scan step.
- Elaboration error if ceil(DATA_WIDTH/4) + ceil(ADDR_WIDTH/4) > HEX_DIGITS.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- key_inc_n, input, 1: raw active-low button; a press steps the address up.
- key_dec_n, input, 1: raw active-low button; a press steps the address down.
- auto_mode, input, 1: level input (switch) that enables auto-scan.
- rd_addr, output, ADDR_WIDTH: memory read address.
- rd_data, input, DATA_WIDTH: memory word for the rd_addr of the previous cycle.
- hex, output, 7*HEX_DIGITS: active-low segments. Digit k occupies [7k+6:7k]; bit 0 is segment a and bit 6 is segment g.
- leds, output, 8: low byte of the displayed word, zero-extended if DATA_WIDTH < 8.

## Operation
Debounce (one instance per key):
- 2-flop synchroniser, then a stable-level counter.
- The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
- The debounced high-to-low transition produces a single 1-cycle press pulse.
- Holding a key generates no repeat.

Address register:
- inc pulse: addr+1, wrapping from 2^ADDR_WIDTH-1 to 0.
- dec pulse: addr-1, wrapping from 0 to 2^ADDR_WIDTH-1.
- inc and dec pulses in the same cycle: addr unchanged.
- rd_addr is driven directly from the address register.

Auto-scan:
- While auto_mode=1, a scan counter runs from 0 to SCAN_CYCLES-1; at the terminal count it increments addr (with wrap) and restarts at 0.
- Press pulses are ignored while auto_mode=1.
- When auto_mode=0, the scan counter is held at 0, so re-entry waits a full period.
- auto_mode is synchronised with 2 flops before use.

Display:
- Each cycle, rd_data is captured together with a copy of the rd_addr from the previous cycle, so displayed data and address always match.
- Digits 0 to ceil(DATA_WIDTH/4)-1 show the data in hex, least significant nibble at digit 0.
- The next ceil(ADDR_WIDTH/4) digits show the address.
- Remaining digits are blank (7'h7F).
- Nibble glyphs follow the standard DE1 encoding, with lowercase b and d.

## Timing
Reset values:
- addr = 0; scan counter = 0; debounce counters = 0; debounced levels = released (1).
- hex = all ones (blank); leds = 0.

Latency:
- Address update at edge N: rd_addr changes after N, rd_data is valid in cycle N+1, and hex/leds update at edge N+2.
- After reset deasserts, the first real display appears at the second edge.

Button path:
- From the first stable low at the pins to the addr change takes DEBOUNCE_CYCLES + 3 edges: 2 for the synchroniser and 1 for the pulse register.

Reset during operation:
- All counters clear and addr returns to 0.
- A key held low through reset registers exactly one press, DEBOUNCE_CYCLES + 3 edges after reset release.

## Configuration
- HART_MEM_VIEWER_AUTOSCAN_EN defined: the auto-scan counter and auto_mode synchroniser are present, and behaviour is as above.
- Macro undefined: the scan logic is not compiled, auto_mode is ignored, and only button presses change addr.

## Test plan
Bench parameters: ADDR_WIDTH=8, DATA_WIDTH=8, DEBOUNCE_CYCLES=4, SCAN_CYCLES=8. Memory model: ram[a] = a ^ 8'hA5, with 1-cycle read latency.
- Reset, then release: during reset hex = all ones, rd_addr = 0, leds = 0. Two edges after release, digit0 = '5', digit1 = 'A', digits 2-3 = '0', digits 4-5 blank, leds = 8'hA5.
- Bounce on key_inc_n (low 3 cycles / high 1 / low 3) leaves rd_addr = 0. Holding it low 100 cycles gives rd_addr = 1 exactly once, DEBOUNCE_CYCLES + 3 edges after it went stably low.
- Wrap: a dec press at addr 0 gives rd_addr = 8'hFF and hex shows 'FF' / '5A'. An inc press at 8'hFF gives 0.
- Simultaneous press of both keys (pulses in the same cycle): rd_addr unchanged. Staggering the presses by 1 cycle gives a net change of 0 after both (+1 then -1).
- With the macro defined, auto_mode=1: rd_addr increments every 8 cycles starting at 0, 1, 2, and an inc press is ignored. Dropping auto_mode freezes addr. Without the macro, auto_mode=1 leaves addr constant.
- Reset asserted mid-scan at addr 5 with key_inc_n held low: addr = 0 and hex goes blank. After release, exactly one increment to 1 at edge DEBOUNCE_CYCLES + 3.
